// File: rtl/address_gen_pkg.sv
// rtl/address_gen_pkg.sv - shared enums, control struct and constants for the address generator
package address_gen_pkg;

    typedef enum logic [1:0] {
        SRC_NEXTPC   = 2'd0,
        SRC_REGFILEA = 2'd1,
        SRC_APLUSB   = 2'd2,
        SRC_RSVD     = 2'd3
    } src_sel_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_e;

    typedef struct packed {
        logic     start;
        logic     calc_en;
        src_sel_e src_sel;
        size_e    size;
    } ctrl_t;

    localparam ctrl_t NO_OP       = '{start: 1'b0, calc_en: 1'b0, src_sel: SRC_NEXTPC,   size: SIZE_BYTE};
    localparam ctrl_t PC_ADDR     = '{start: 1'b1, calc_en: 1'b0, src_sel: SRC_NEXTPC,   size: SIZE_WORD};
    localparam ctrl_t RFA_ADDR    = '{start: 1'b1, calc_en: 1'b0, src_sel: SRC_REGFILEA, size: SIZE_WORD};
    localparam ctrl_t APLUSB_ADDR = '{start: 1'b1, calc_en: 1'b0, src_sel: SRC_APLUSB,   size: SIZE_WORD};
    localparam ctrl_t APLUSB_CALC = '{start: 1'b0, calc_en: 1'b1, src_sel: SRC_APLUSB,   size: SIZE_WORD};

    // Reserved size behaves as word.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input size_e sz);
        case (sz)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = addr_lo[0];
            default:   is_misaligned = |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/address_gen_unit_align_check.sv
// rtl/address_gen_unit_align_check.sv - combinational alignment check of an address against access size
module align_check
    import address_gen_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  size_e      size,
    output logic       misaligned
);

    assign misaligned = is_misaligned(addr_lo, size);

endmodule

// File: rtl/address_gen_unit.sv
// rtl/address_gen_unit.sv - burst address generator with source select, stride and alignment check
module address_gen_unit
    import address_gen_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        src_sel,
    input  logic              start,
    input  logic              calc_en,
    input  logic [1:0]        size,
    input  logic [LEN_W-1:0]  burst_len,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic [ADDR_W-1:0] regfile_a,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [ADDR_W-1:0] b_reg,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        lane_sel,
    output logic [ADDR_W-1:0] calc_addr,
    output logic              busy,
    output logic              done,
    output logic              misaligned
);

    state_e             r_state;
    logic [ADDR_W-1:0]  r_address;
    logic [LEN_W-1:0]   r_beats_left;
    logic [ADDR_W-1:0]  r_stride;
    logic [ADDR_W-1:0]  r_calc_addr;
    logic               r_done;
    logic               r_misaligned;

    state_e             w_state_nxt;
    logic [ADDR_W-1:0]  w_address_nxt;
    logic [LEN_W-1:0]   w_beats_nxt;
    logic [ADDR_W-1:0]  w_stride_nxt;
    logic               w_done_nxt;
    logic               w_mis_nxt;

    ctrl_t              w_ctrl;
    logic [ADDR_W-1:0]  w_sum;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic               w_misaligned;

    assign w_ctrl = '{start: start, calc_en: calc_en,
                      src_sel: src_sel_e'(src_sel), size: size_e'(size)};
    assign w_sum  = a_reg + b_reg;

    always_comb begin
        w_sel_addr = next_pc;
        case (w_ctrl.src_sel)
            SRC_REGFILEA: w_sel_addr = regfile_a;
            SRC_APLUSB:   w_sel_addr = w_sum;
            default:      w_sel_addr = next_pc;
        endcase
    end

    align_check u_align_check (
        .addr_lo    (w_sel_addr[1:0]),
        .size       (w_ctrl.size),
        .misaligned (w_misaligned)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_address_nxt = r_address;
        w_beats_nxt   = r_beats_left;
        w_stride_nxt  = r_stride;
        w_done_nxt    = 1'b0;
        w_mis_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ctrl.start) begin
                    if (w_misaligned) begin
                        w_mis_nxt = 1'b1;
                    end else begin
                        w_state_nxt   = ST_ISSUE;
                        w_address_nxt = w_sel_addr;
                        w_beats_nxt   = burst_len;
                        w_stride_nxt  = stride;
                    end
                end
            end
            ST_ISSUE: begin
                // Only the first beat is alignment-checked; later beats trust the stride.
                if (addr_ready) begin
                    if (r_beats_left != '0) begin
                        w_address_nxt = r_address + r_stride;
                        w_beats_nxt   = r_beats_left - LEN_W'(1);
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_address    <= '0;
            r_beats_left <= '0;
            r_stride     <= '0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_address    <= w_address_nxt;
            r_beats_left <= w_beats_nxt;
            r_stride     <= w_stride_nxt;
            r_done       <= w_done_nxt;
            r_misaligned <= w_mis_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_calc_addr <= '0;
        end else if (w_ctrl.calc_en) begin
            r_calc_addr <= w_sum;
        end
    end

    assign addr_valid = (r_state == ST_ISSUE);
    assign busy       = (r_state == ST_ISSUE);
    assign address    = r_address;
    assign lane_sel   = r_address[1:0];
    assign calc_addr  = r_calc_addr;
    assign done       = r_done;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_address_gen_unit.sv
// tb/tb_address_gen_unit.sv - table-driven scoreboard bench for address_gen_unit
module tb_address_gen_unit;
    import address_gen_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  src_sel;
    logic        start;
    logic        calc_en;
    logic [1:0]  size;
    logic [3:0]  burst_len;
    logic [31:0] stride, next_pc, regfile_a, a_reg, b_reg;
    logic        addr_valid, addr_ready;
    logic [31:0] address, calc_addr;
    logic [1:0]  lane_sel;
    logic        busy, done, misaligned;

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  src;
        logic [1:0]  sz;
        logic [31:0] pc, rfa, a, b;
        logic [3:0]  len;
        logic [31:0] strd;
        bit          exp_mis;
    } vec_t;
    vec_t vecs[10];

    address_gen_unit #(.ADDR_W(32), .LEN_W(4)) dut (
        .clk(clk), .reset(reset), .src_sel(src_sel), .start(start), .calc_en(calc_en),
        .size(size), .burst_len(burst_len), .stride(stride), .next_pc(next_pc),
        .regfile_a(regfile_a), .a_reg(a_reg), .b_reg(b_reg), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .address(address), .lane_sel(lane_sel),
        .calc_addr(calc_addr), .busy(busy), .done(done), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (busy !== addr_valid) begin
                failures++;
                $display("FAIL busy_eq_valid actual=%0b required=%0b", busy, addr_valid);
            end
            if (addr_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=0x%0h required=none", address);
                end else begin
                    check("beat_address", address, exp_q[0]);
                    check("beat_lane", {30'd0, lane_sel}, {30'd0, exp_q[0][1:0]});
                    if (addr_ready) begin
                        void'(exp_q.pop_front());
                        hs_cnt++;
                    end
                end
            end
        end
    end

    task automatic run_vec(input vec_t v, input int stall_beat, input int stall_len, input int hold_start);
        logic [31:0] a;
        int waited, stalled;
        bit seen_done;
        case (v.src)
            2'd1:    a = v.rfa;
            2'd2:    a = v.a + v.b;
            default: a = v.pc;
        endcase
        src_sel = v.src; size = v.sz; next_pc = v.pc; regfile_a = v.rfa;
        a_reg = v.a; b_reg = v.b; burst_len = v.len; stride = v.strd;
        start = 1'b1; addr_ready = 1'b1; hs_cnt = 0;
        if (!v.exp_mis) begin
            for (int i = 0; i <= int'(v.len); i++) begin
                exp_q.push_back(a);
                a = a + v.strd;
            end
        end
        tick();
        start = (hold_start > 0);
        if (v.exp_mis) begin
            check("mis_pulse", {31'd0, misaligned}, 32'd1);
            check("mis_no_valid", {31'd0, addr_valid}, 32'd0);
            tick();
            check("mis_pulse_end", {31'd0, misaligned}, 32'd0);
            return;
        end
        check("first_valid_latency", {31'd0, addr_valid}, 32'd1);
        check("no_mis_aligned", {31'd0, misaligned}, 32'd0);
        stalled = 0; seen_done = 0; waited = 0;
        while (!seen_done && waited < 100) begin
            start = (waited < hold_start);
            if (start) next_pc = 32'h0000_0800;
            if (hs_cnt == stall_beat && stalled < stall_len) begin
                addr_ready = 1'b0;
                stalled++;
            end else begin
                addr_ready = 1'b1;
            end
            tick();
            waited++;
            if (done) seen_done = 1;
        end
        start = 1'b0;
        check("done_seen", {31'd0, seen_done}, 32'd1);
        check("queue_drained_at_done", exp_q.size(), 32'd0);
        check("idle_at_done", {31'd0, addr_valid}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{2'd0, 2'd2, 32'h100, 32'h0,   32'h0,    32'h0,  4'd0,  32'h0,        1'b0};
        vecs[1] = '{2'd2, 2'd2, 32'h0,   32'h0,   32'h1000, 32'h20, 4'd3,  32'h4,        1'b0};
        vecs[2] = '{2'd1, 2'd2, 32'h0,   32'h202, 32'h0,    32'h0,  4'd0,  32'h0,        1'b1};
        vecs[3] = '{2'd1, 2'd1, 32'h0,   32'h202, 32'h0,    32'h0,  4'd0,  32'h0,        1'b0};
        vecs[4] = '{2'd3, 2'd0, 32'h301, 32'h0,   32'h0,    32'h0,  4'd1,  32'h1,        1'b0};
        vecs[5] = '{2'd0, 2'd2, 32'h4,   32'h0,   32'h0,    32'h0,  4'd2,  32'hFFFFFFFC, 1'b0};
        vecs[6] = '{2'd3, 2'd3, 32'h6,   32'h0,   32'h0,    32'h0,  4'd0,  32'h0,        1'b1};
        vecs[7] = '{2'd2, 2'd1, 32'h0,   32'h0,   32'h10,   32'h3,  4'd0,  32'h0,        1'b1};
        vecs[8] = '{2'd0, 2'd0, 32'h0,   32'h0,   32'h0,    32'h0,  4'd15, 32'h10,       1'b0};
        vecs[9] = '{2'd0, 2'd1, 32'h102, 32'h0,   32'h0,    32'h0,  4'd0,  32'h0,        1'b0};

        {src_sel, start, calc_en, size} = {NO_OP.src_sel, NO_OP.start, NO_OP.calc_en, NO_OP.size};
        burst_len = '0; stride = '0; next_pc = '0; regfile_a = '0;
        a_reg = '0; b_reg = '0; addr_ready = 1'b0;
        reset = 1'b1;
        tick(); tick();
        check("rst_valid", {31'd0, addr_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("rst_address", address, 32'h0);
        check("rst_lane", {30'd0, lane_sel}, 32'd0);
        check("rst_calc", calc_addr, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], -1, 0, 0);
        run_vec(vecs[1], 1, 3, 0);
        run_vec(vecs[1], -1, 0, 2);

        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);

        a_reg = 32'hFFFF_FFF0; b_reg = 32'h20; calc_en = APLUSB_CALC.calc_en;
        tick();
        check("calc_trunc", calc_addr, 32'h10);
        calc_en = 1'b0; a_reg = 32'h5;
        tick();
        check("calc_hold", calc_addr, 32'h10);

        src_sel = PC_ADDR.src_sel; size = PC_ADDR.size; next_pc = 32'h2000;
        burst_len = 4'd3; stride = 32'h4; start = 1'b1; addr_ready = 1'b1; hs_cnt = 0;
        exp_q.push_back(32'h2000); exp_q.push_back(32'h2004);
        exp_q.push_back(32'h2008); exp_q.push_back(32'h200C);
        a_reg = 32'h7; b_reg = 32'h1; calc_en = 1'b1;
        tick();
        start = 1'b0;
        tick();
        calc_en = 1'b0;
        check("calc_in_issue", calc_addr, 32'h8);
        #2 reset = 1'b1;
        #1;
        check("midrst_valid", {31'd0, addr_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_address", address, 32'h0);
        check("midrst_calc", calc_addr, 32'h0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_done", {31'd0, done}, 32'd0);
            check("midrst_idle", {31'd0, addr_valid}, 32'd0);
        end
        run_vec(vecs[0], -1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/address_gen_unit.md
ADDRESS_GEN_UNIT -- requirements
Module: address_gen_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address/operand width (>=8).
REQ-002 SHALL have parameter LEN_W, default 4, burst beat-count width; max burst 2^LEN_W beats.
REQ-003 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port src_sel  in  2  source: 0 NEXTPC, 1 REGFILEA, 2 APLUSB, 3 reserved (treated as NEXTPC).
REQ-006 SHALL have port start  in  1  launch request, sampled in IDLE only.
REQ-007 SHALL have port calc_en  in  1  load calc_addr with a_reg+b_reg.
REQ-008 SHALL have port size  in  2  access size: 0 byte, 1 half, 2 word, 3 reserved (treated as word).
REQ-009 SHALL have port burst_len  in  LEN_W  beats minus one, sampled with start.
REQ-010 SHALL have port stride  in  ADDR_W  two's-complement increment per beat, sampled with start.
REQ-011 SHALL have ports next_pc, regfile_a, a_reg, b_reg  in  ADDR_W  address sources.
REQ-012 SHALL have port addr_valid  out  1  address holds a beat.
REQ-013 SHALL have port addr_ready  in  1  consumer accepts beat.
REQ-014 SHALL have port address  out  ADDR_W  current beat address (registered).
REQ-015 SHALL have port lane_sel  out  2  address[1:0] of current beat (registered).
REQ-016 SHALL have port calc_addr  out  ADDR_W  registered a_reg+b_reg.
REQ-017 SHALL have ports busy, done, misaligned  out  1 each  status.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE.
REQ-019 In IDLE, start=1: selected source (APLUSB = combinational a_reg+b_reg) SHALL be checked for alignment against size.
REQ-020 Aligned start: next cycle address=selected, lane_sel=its [1:0], beats_left=burst_len, stride latched, state ISSUE.
REQ-021 Misaligned start: misaligned SHALL pulse 1 cycle, address/lane_sel unchanged, state stays IDLE.
REQ-022 addr_valid=1 and busy=1 exactly while in ISSUE; both registered-state decodes, no combinational path from addr_ready.
REQ-023 ISSUE with addr_ready=1 and beats_left!=0: address+=stride (mod 2^ADDR_W), lane_sel updated, beats_left-=1.
REQ-024 ISSUE with addr_ready=1 and beats_left==0: return to IDLE, done SHALL pulse 1 cycle in the following cycle.
REQ-025 ISSUE with addr_ready=0: address, lane_sel, beats_left SHALL hold.
REQ-026 start while in ISSUE SHALL be ignored; start in the cycle done is high SHALL be accepted.
REQ-027 Beats after the first SHALL NOT be alignment-checked; stride alignment is the requester's responsibility.
REQ-028 calc_addr SHALL load a_reg+b_reg (truncated to ADDR_W) on any cycle with calc_en=1, independent of FSM state.
REQ-029 Latency start->first addr_valid SHALL be 1 cycle; throughput 1 beat/cycle with addr_ready held high.

Reset
REQ-030 Reset SHALL asynchronously force state IDLE, address=0, lane_sel=0, calc_addr=0, beats_left=0, addr_valid/busy/done/misaligned=0.
REQ-031 Reset mid-burst SHALL abort the burst with no done pulse.

Structure
REQ-032 Source-select enum, size enum, FSM state enum, and control struct {start, calc_en, src_sel, size} SHALL live in a shared package address_gen_pkg with named control constants (NO_OP, PC_ADDR, RFA_ADDR, APLUSB_ADDR, APLUSB_CALC).
REQ-033 SHALL contain one sub-module, align_check (combinational: address, size -> misaligned).

Verification
REQ-034 Reset, then start src=NEXTPC next_pc=0x100 len=0 size=word, ready=1 -> address=0x100 valid 1 cycle, done pulse next cycle.
REQ-035 start src=APLUSB a=0x1000 b=0x20 len=3 stride=4, ready=1 -> addresses 0x1020,0x1024,0x1028,0x102C on consecutive cycles, then done.
REQ-036 Same burst with ready low on 2nd beat for 3 cycles -> 0x1024 held 3 cycles, no beat lost, done after 0x102C.
REQ-037 start src=REGFILEA regfile_a=0x202 size=word -> misaligned pulse, valid stays 0; same with size=half -> accepted, lane_sel=2.
REQ-038 stride=0xFFFFFFFC base=0x4 len=2 -> 0x4,0x0,0xFFFFFFFC (wrap).
REQ-039 Assert reset during beat 2 of a 4-beat burst -> valid=0, address=0, no done; new start after reset works.
